// File: rtl/dcache_bus_pkg.sv
// Shared definitions for the core-to-D-cache bus.
// Tag layout (13 bits): {type[12:11], space[10:9], kind[8:7], 7'b0}.
// Also holds the drain-FSM state encoding used by the write responder.
package dcache_bus_pkg;

  localparam int TAG_W         = 13;
  localparam int TAG_TYPE_MSB  = 12;
  localparam int TAG_TYPE_LSB  = 11;
  localparam int TAG_SPACE_MSB = 10;
  localparam int TAG_SPACE_LSB = 9;
  localparam int TAG_KIND_MSB  = 8;
  localparam int TAG_KIND_LSB  = 7;

  typedef enum logic [1:0] {
    REQ_READ  = 2'b00,
    REQ_WRITE = 2'b01
  } req_type_t;

  typedef enum logic [1:0] {
    MEMORY = 2'b00,
    IO     = 2'b01
  } req_space_t;

  typedef enum logic [1:0] {
    DATA  = 2'b00,
    INSTR = 2'b01
  } req_kind_t;

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'b00,
    DRAIN_ISSUE = 2'b01,
    DRAIN_WAIT  = 2'b10,
    DRAIN_ACK   = 2'b11
  } drain_state_t;

  // Extract the request type field from a tag.
  function automatic req_type_t tag_type(input logic [TAG_W-1:0] tag);
    return req_type_t'(tag[TAG_TYPE_MSB:TAG_TYPE_LSB]);
  endfunction

  // Assemble a tag from its fields; the low 7 bits are always zero.
  function automatic logic [TAG_W-1:0] make_tag(input req_type_t  t,
                                                input req_space_t s,
                                                input req_kind_t  k);
    return {t, s, k, 7'b000_0000};
  endfunction

endpackage

// File: rtl/wr_buffer_fifo.sv
// In-order write buffer: circular FIFO of DEPTH entries of WIDTH bits.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   push_i/push_data_i - write an entry at the tail (ignored when full)
//   pop_i           - retire the head entry (ignored when empty)
//   head_data_o     - entry at the head
//   full_o/empty_o  - occupancy flags (registered count based)
//   count_o         - occupied entries
//   count_next_o    - occupancy after the current edge
// DEPTH must be a power of two so the pointers wrap naturally.
module wr_buffer_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o       = (count_q == CNT_W'(DEPTH));
  assign empty_o      = (count_q == {CNT_W{1'b0}});
  assign do_push_s    = push_i && !full_o;
  assign do_pop_s     = pop_i && !empty_o;
  assign head_data_o  = mem_q[head_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

  // Next pointer and occupancy values.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_push_s) begin
      tail_d = tail_q + 1'b1;
    end else begin
      tail_d = tail_q;
    end
    if (do_pop_s) begin
      head_d = head_q + 1'b1;
    end else begin
      head_d = head_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/dcache_write_responder.sv
// Cache-side responder for core write requests.
// Accepts WRITE requests into an in-order buffer (reqack one cycle after
// reqcyc), drains each entry to the memory write port and pulses writeack
// once per committed write.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   core_reqcyc/req/reqdata/reqtag - core request (only WRITE type accepted)
//   core_reqack                 - 1-cycle accept pulse
//   core_writeack               - 1-cycle pulse per committed write, in order
//   mem_wr_valid/addr/data      - memory write request, held until ready
//   mem_wr_ready, mem_wr_done   - memory handshake / completion
//   pending_count               - occupied buffer entries
//   busy                        - entries pending or drain in progress
module dcache_write_responder
  import dcache_bus_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = dcache_bus_pkg::TAG_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   core_reqcyc,
  input  logic [ADDR_W-1:0]      core_req,
  input  logic [DATA_W-1:0]      core_reqdata,
  input  logic [TAG_W-1:0]       core_reqtag,
  output logic                   core_reqack,
  output logic                   core_writeack,
  output logic                   mem_wr_valid,
  output logic [ADDR_W-1:0]      mem_wr_addr,
  output logic [DATA_W-1:0]      mem_wr_data,
  input  logic                   mem_wr_ready,
  input  logic                   mem_wr_done,
  output logic [$clog2(DEPTH):0] pending_count,
  output logic                   busy
);

  localparam int ENTRY_W = ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  drain_state_t        state_q, state_d;
  logic                core_reqack_q;
  logic                core_writeack_q;
  logic                mem_wr_valid_q;
  logic [ADDR_W-1:0]   mem_wr_addr_q;
  logic [DATA_W-1:0]   mem_wr_data_q;
  logic                busy_q;

  logic                accept_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [ENTRY_W-1:0]  head_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic [CNT_W-1:0]    fifo_count_next_s;

  // The reqack term stops the still-high reqcyc of the request just
  // acknowledged from being accepted a second time. Full is the pre-pop
  // value, so nothing is pushed in a cycle that starts full.
  assign accept_s = core_reqcyc && (tag_type(core_reqtag) == REQ_WRITE) &&
                    !fifo_full_s && !core_reqack_q;
  assign pop_s    = (state_q == DRAIN_ACK);

  wr_buffer_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (accept_s),
    .push_data_i  ({core_req, core_reqdata}),
    .pop_i        (pop_s),
    .head_data_o  (head_s),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s),
    .count_o      (fifo_count_s),
    .count_next_o (fifo_count_next_s)
  );

  // Drain FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DRAIN_IDLE: begin
        if (!fifo_empty_s) begin
          state_d = DRAIN_ISSUE;
        end else begin
          state_d = DRAIN_IDLE;
        end
      end
      DRAIN_ISSUE: begin
        // Ready and done together skip the wait state entirely.
        if (mem_wr_ready && mem_wr_done) begin
          state_d = DRAIN_ACK;
        end else if (mem_wr_ready) begin
          state_d = DRAIN_WAIT;
        end else begin
          state_d = DRAIN_ISSUE;
        end
      end
      DRAIN_WAIT: begin
        if (mem_wr_done) begin
          state_d = DRAIN_ACK;
        end else begin
          state_d = DRAIN_WAIT;
        end
      end
      DRAIN_ACK: state_d = DRAIN_IDLE;
      default:   state_d = DRAIN_IDLE;
    endcase
  end

  // Drain state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DRAIN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output registers, decoded from next state so they line up with it.
  // The head entry cannot change while in ISSUE (pops happen only in ACK),
  // so addr/data stay stable under back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_reqack_q   <= 1'b0;
      core_writeack_q <= 1'b0;
      mem_wr_valid_q  <= 1'b0;
      mem_wr_addr_q   <= {ADDR_W{1'b0}};
      mem_wr_data_q   <= {DATA_W{1'b0}};
      busy_q          <= 1'b0;
    end else begin
      core_reqack_q   <= accept_s;
      core_writeack_q <= (state_d == DRAIN_ACK);
      mem_wr_valid_q  <= (state_d == DRAIN_ISSUE);
      if (state_d == DRAIN_ISSUE) begin
        mem_wr_addr_q <= head_s[ENTRY_W-1 -: ADDR_W];
        mem_wr_data_q <= head_s[DATA_W-1:0];
      end else begin
        mem_wr_addr_q <= {ADDR_W{1'b0}};
        mem_wr_data_q <= {DATA_W{1'b0}};
      end
      busy_q <= (fifo_count_next_s != {CNT_W{1'b0}}) || (state_d != DRAIN_IDLE);
    end
  end

  assign core_reqack   = core_reqack_q;
  assign core_writeack = core_writeack_q;
  assign mem_wr_valid  = mem_wr_valid_q;
  assign mem_wr_addr   = mem_wr_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign pending_count = fifo_count_s;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dcache_write_responder.sv
module tb_dcache_write_responder;
  import dcache_bus_pkg::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              core_reqcyc;
  logic [ADDR_W-1:0] core_req;
  logic [DATA_W-1:0] core_reqdata;
  logic [TAG_W-1:0]  core_reqtag;
  logic              core_reqack;
  logic              core_writeack;
  logic              mem_wr_valid;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;
  logic              mem_wr_done;
  logic [CW-1:0]     pending_count;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int seen_wacks;
  logic [TAG_W-1:0]  wr_tag, rd_tag;
  logic [ADDR_W-1:0] exp_addr_q[$], seen_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$], seen_data_q[$];

  always #5 clk = ~clk;

  dcache_write_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .core_reqcyc(core_reqcyc), .core_req(core_req), .core_reqdata(core_reqdata),
    .core_reqtag(core_reqtag), .core_reqack(core_reqack), .core_writeack(core_writeack),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .mem_wr_done(mem_wr_done),
    .pending_count(pending_count), .busy(busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    core_reqcyc = 1'b0; core_req = '0; core_reqdata = '0; core_reqtag = wr_tag;
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
  endtask

  // Core-side driver: present a write, hold until reqack seen, then drop.
  task automatic send_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output bit acked);
    core_req = a; core_reqdata = d; core_reqtag = wr_tag; core_reqcyc = 1'b1;
    acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      tick();
      if (core_reqack === 1'b1) begin acked = 1'b1; core_reqcyc = 1'b0; end
    end
    core_reqcyc = 1'b0;
  endtask

  // Memory-side responder: ready always, random done; records issued writes.
  task automatic mem_respond(input int max_cycles, output int n_racks, output bit drained);
    n_racks = 0; drained = 1'b0;
    for (int i = 0; i < max_cycles && !drained; i++) begin
      tick();
      if (core_writeack === 1'b1) seen_wacks++;
      if (core_reqcyc && core_reqack === 1'b1) begin n_racks++; core_reqcyc = 1'b0; end
      if (pending_count === CW'(0) && busy === 1'b0 && !core_reqcyc) begin
        drained = 1'b1;
      end else begin
        mem_wr_ready = 1'b1;
        mem_wr_done  = ($urandom_range(0, 1) == 1);
        if (mem_wr_valid === 1'b1) begin
          seen_addr_q.push_back(mem_wr_addr); seen_data_q.push_back(mem_wr_data);
        end
      end
    end
    mem_wr_ready = 1'b0; mem_wr_done = 1'b0;
  endtask

  task automatic clear_queues();
    exp_addr_q.delete(); exp_data_q.delete(); seen_addr_q.delete(); seen_data_q.delete();
    seen_wacks = 0;
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1'b1;
    tick(); tick();
    n_checks++; if (core_reqack !== 1'b0) begin n_fail++; $display("FAIL reset_reqack: got %b want 0", core_reqack); end
    n_checks++; if (core_writeack !== 1'b0) begin n_fail++; $display("FAIL reset_writeack: got %b want 0", core_writeack); end
    n_checks++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", mem_wr_valid); end
    n_checks++; if (mem_wr_addr !== 64'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", mem_wr_addr); end
    n_checks++; if (mem_wr_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", mem_wr_data); end
    n_checks++; if (pending_count !== CW'(0)) begin n_fail++; $display("FAIL reset_pending: got %0d want 0", pending_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    core_req = 64'h1000; core_reqdata = 64'hDEADBEEF; core_reqtag = wr_tag; core_reqcyc = 1'b1;
    tick();
    n_checks++; if (core_reqack !== 1'b1) begin n_fail++; $display("FAIL single_reqack: got %b want 1", core_reqack); end
    n_checks++; if (pending_count !== CW'(1)) begin n_fail++; $display("FAIL single_pending1: got %0d want 1", pending_count); end
    core_reqcyc = 1'b0;
    tick();
    n_checks++; if (core_reqack !== 1'b0) begin n_fail++; $display("FAIL single_reqack_low: got %b want 0", core_reqack); end
    n_checks++; if (mem_wr_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", mem_wr_valid); end
    n_checks++; if (mem_wr_addr !== 64'h1000) begin n_fail++; $display("FAIL single_addr: got %h want 1000", mem_wr_addr); end
    n_checks++; if (mem_wr_data !== 64'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", mem_wr_data); end
    mem_wr_ready = 1'b1;
    tick();
    n_checks++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", mem_wr_valid); end
    n_checks++; if (core_writeack !== 1'b0) begin n_fail++; $display("FAIL single_early_wack: got %b want 0", core_writeack); end
    mem_wr_ready = 1'b0; mem_wr_done = 1'b1;
    tick();
    n_checks++; if (core_writeack !== 1'b1) begin n_fail++; $display("FAIL single_wack: got %b want 1", core_writeack); end
    mem_wr_done = 1'b0;
    tick();
    n_checks++; if (core_writeack !== 1'b0) begin n_fail++; $display("FAIL single_wack_pulse: got %b want 0", core_writeack); end
    n_checks++; if (pending_count !== CW'(0)) begin n_fail++; $display("FAIL single_pending0: got %0d want 0", pending_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_dup_guard();
    int n_ack, n_racks; bit drained;
    clear_queues();
    core_req = 64'h2000; core_reqdata = {$urandom, $urandom}; core_reqtag = wr_tag; core_reqcyc = 1'b1;
    exp_addr_q.push_back(core_req); exp_data_q.push_back(core_reqdata);
    n_ack = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_reqack === 1'b1) n_ack++;
      if (i == 1) core_reqcyc = 1'b0;  // held through the reqack cycle
    end
    n_checks++; if (n_ack != 1) begin n_fail++; $display("FAIL dup_reqack_count: got %0d want 1", n_ack); end
    n_checks++; if (pending_count !== CW'(1)) begin n_fail++; $display("FAIL dup_pending: got %0d want 1", pending_count); end
    mem_respond(100, n_racks, drained);
    n_checks++; if (!drained || seen_wacks != 1) begin n_fail++; $display("FAIL dup_drain: drained %b wacks %0d want 1", drained, seen_wacks); end
    n_checks++; if (seen_addr_q.size() != 1 || seen_addr_q[0] !== exp_addr_q[0] || seen_data_q[0] !== exp_data_q[0])
      begin n_fail++; $display("FAIL dup_mem_write: got %0d writes, want 1 to %h", seen_addr_q.size(), exp_addr_q[0]); end
  endtask

  task automatic test_fill_full();
    bit acked, drained; int n_ack, n_racks; logic [DATA_W-1:0] d;
    clear_queues();
    for (int k = 0; k < DEPTH; k++) begin
      d = {$urandom, $urandom};
      send_write(ADDR_W'(k * 8), d, acked);
      exp_addr_q.push_back(ADDR_W'(k * 8)); exp_data_q.push_back(d);
      n_checks++; if (!acked) begin n_fail++; $display("FAIL fill_ack%0d: got 0 want 1", k); end
    end
    n_checks++; if (pending_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_pending: got %0d want %0d", pending_count, DEPTH); end
    core_req = 64'h20; core_reqdata = {$urandom, $urandom}; core_reqcyc = 1'b1;
    exp_addr_q.push_back(core_req); exp_data_q.push_back(core_reqdata);
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (core_reqack === 1'b1) n_ack++; end
    n_checks++; if (n_ack != 0) begin n_fail++; $display("FAIL full_no_ack: got %0d acks want 0", n_ack); end
    n_checks++; if (pending_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_pending: got %0d want %0d", pending_count, DEPTH); end
    mem_respond(300, n_racks, drained);
    n_checks++; if (n_racks != 1) begin n_fail++; $display("FAIL full_fifth_ack: got %0d want 1", n_racks); end
    n_checks++; if (!drained || seen_wacks != 5) begin n_fail++; $display("FAIL full_wacks: drained %b got %0d want 5", drained, seen_wacks); end
    n_checks++; if (seen_addr_q.size() != 5) begin n_fail++; $display("FAIL full_write_count: got %0d want 5", seen_addr_q.size()); end
    for (int k = 0; k < 5 && k < seen_addr_q.size(); k++) begin
      n_checks++;
      if (seen_addr_q[k] !== exp_addr_q[k] || seen_data_q[k] !== exp_data_q[k]) begin
        n_fail++; $display("FAIL full_order%0d: got %h/%h want %h/%h", k, seen_addr_q[k], seen_data_q[k], exp_addr_q[k], exp_data_q[k]);
      end
    end
  endtask

  task automatic test_read_ignored();
    core_req = {$urandom, $urandom}; core_reqdata = {$urandom, $urandom}; core_reqtag = rd_tag; core_reqcyc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (core_reqack !== 1'b0) begin n_fail++; $display("FAIL read_reqack c%0d: got %b want 0", i, core_reqack); end
      n_checks++; if (pending_count !== CW'(0)) begin n_fail++; $display("FAIL read_pending c%0d: got %0d want 0", i, pending_count); end
      n_checks++; if (mem_wr_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid c%0d: got %b want 0", i, mem_wr_valid); end
    end
    core_reqcyc = 1'b0; core_reqtag = wr_tag;
  endtask

  task automatic test_backpressure();
    bit acked, seen; logic [DATA_W-1:0] d;
    d = {$urandom, $urandom};
    send_write(64'h3000, d, acked);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (mem_wr_valid === 1'b1) seen = 1'b1; else tick();
    end
    n_checks++; if (!acked || !seen) begin n_fail++; $display("FAIL bp_issue: acked %b valid %b want 1/1", acked, seen); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 64'h3000 || mem_wr_data !== d || core_writeack !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold c%0d: got v%b %h/%h wack %b want v1 3000/%h wack 0", i, mem_wr_valid, mem_wr_addr, mem_wr_data, core_writeack, d);
      end
      tick();
    end
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;
    n_checks++; if (mem_wr_valid !== 1'b0 || core_writeack !== 1'b0) begin n_fail++; $display("FAIL bp_accept: got v%b wack %b want 0/0", mem_wr_valid, core_writeack); end
    tick();
    n_checks++; if (core_writeack !== 1'b0) begin n_fail++; $display("FAIL bp_wack_before_done: got %b want 0", core_writeack); end
    mem_wr_done = 1'b1;
    tick();
    mem_wr_done = 1'b0;
    n_checks++; if (core_writeack !== 1'b1) begin n_fail++; $display("FAIL bp_wack: got %b want 1", core_writeack); end
    tick();
    n_checks++; if (pending_count !== CW'(0)) begin n_fail++; $display("FAIL bp_pending: got %0d want 0", pending_count); end
  endtask

  task automatic test_reset_mid_drain();
    bit a0, a1, seen;
    send_write(64'h4000, {$urandom, $urandom}, a0);
    send_write(64'h4008, {$urandom, $urandom}, a1);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      if (mem_wr_valid === 1'b1) seen = 1'b1; else tick();
    end
    mem_wr_ready = 1'b1;
    tick();
    mem_wr_ready = 1'b0;
    n_checks++; if (!seen || mem_wr_valid !== 1'b0 || pending_count !== CW'(2)) begin
      n_fail++; $display("FAIL rst_setup: issued %b valid %b pending %0d want 1/0/2", seen, mem_wr_valid, pending_count); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({core_reqack, core_writeack, mem_wr_valid, busy} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_flags: got %b want 0000", {core_reqack, core_writeack, mem_wr_valid, busy}); end
    n_checks++; if (mem_wr_addr !== 64'h0 || mem_wr_data !== 64'h0) begin n_fail++; $display("FAIL rst_bus: got %h/%h want 0/0", mem_wr_addr, mem_wr_data); end
    n_checks++; if (pending_count !== CW'(0)) begin n_fail++; $display("FAIL rst_pending: got %0d want 0", pending_count); end
    mem_wr_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (core_writeack !== 1'b0 || mem_wr_valid !== 1'b0 || pending_count !== CW'(0)) begin
        n_fail++; $display("FAIL rst_stale_done c%0d: wack %b valid %b pending %0d want 0/0/0", i, core_writeack, mem_wr_valid, pending_count); end
    end
    mem_wr_done = 1'b0;
  endtask

  // Random traffic vs. a queue model: order, data, occupancy and holding.
  task automatic test_random();
    localparam int N = 40;
    int n_sent, n_acc, n_wack, cycles;
    bit v_prev, r_prev;
    logic [ADDR_W-1:0] a_prev, q_a[$];
    logic [DATA_W-1:0] d_prev, q_d[$];
    idle_inputs();
    n_sent = 0; n_acc = 0; n_wack = 0; cycles = 0; v_prev = 0; r_prev = 0; a_prev = '0; d_prev = '0;
    while (n_wack < N && cycles < 4000) begin
      tick(); cycles++;
      if (v_prev && !r_prev) begin
        n_checks++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== a_prev || mem_wr_data !== d_prev) begin
          n_fail++; $display("FAIL rnd_hold: got v%b %h/%h want v1 %h/%h", mem_wr_valid, mem_wr_addr, mem_wr_data, a_prev, d_prev); end
      end
      if (core_reqack === 1'b1) begin
        n_checks++; if (!core_reqcyc) begin n_fail++; $display("FAIL rnd_spurious_ack: got 1 want 0"); end
        q_a.push_back(core_req); q_d.push_back(core_reqdata); n_acc++; core_reqcyc = 1'b0;
      end
      n_checks++; if (pending_count !== CW'(n_acc - n_wack)) begin
        n_fail++; $display("FAIL rnd_pending: got %0d want %0d", pending_count, n_acc - n_wack); end
      if (core_writeack === 1'b1) n_wack++;
      mem_wr_ready = ($urandom_range(0, 3) != 0);
      mem_wr_done  = ($urandom_range(0, 1) == 1);
      if (mem_wr_valid === 1'b1 && mem_wr_ready) begin
        n_checks++;
        if (q_a.size() == 0) begin n_fail++; $display("FAIL rnd_extra_write: got %h want none", mem_wr_addr); end
        else begin
          if (mem_wr_addr !== q_a[0] || mem_wr_data !== q_d[0]) begin
            n_fail++; $display("FAIL rnd_write: got %h/%h want %h/%h", mem_wr_addr, mem_wr_data, q_a[0], q_d[0]); end
          void'(q_a.pop_front()); void'(q_d.pop_front());
        end
      end
      v_prev = (mem_wr_valid === 1'b1); r_prev = mem_wr_ready; a_prev = mem_wr_addr; d_prev = mem_wr_data;
      if (!core_reqcyc && n_sent < N && $urandom_range(0, 1) == 1) begin
        core_req = {$urandom, $urandom}; core_reqdata = {$urandom, $urandom}; core_reqtag = wr_tag;
        core_reqcyc = 1'b1; n_sent++;
      end
    end
    idle_inputs();
    n_checks++; if (n_acc != N || n_wack != N || q_a.size() != 0) begin
      n_fail++; $display("FAIL rnd_totals: acc %0d wack %0d left %0d want %0d/%0d/0", n_acc, n_wack, q_a.size(), N, N); end
  endtask

  initial begin
    wr_tag = make_tag(REQ_WRITE, MEMORY, DATA);
    rd_tag = make_tag(REQ_READ, MEMORY, DATA);
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_dup_guard();
    test_fill_full();
    test_read_ignored();
    test_backpressure();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_write_responder.md
Name: dcache_write_responder

Overview:
- Responder (cache side) of the core-to-D-cache write protocol. The core pipeline drives it with reqcyc/req/reqdata/reqtag and waits for reqack, then for writeack.
- The block accepts WRITE requests into a small in-order write buffer, returns reqack, drains each entry to the backing memory write port, and pulses writeack per committed write.
- It sits between the core's data-cache bus and the memory/L2 write channel. Read requests are not handled here.

Parameters:
- ADDR_W, 64, request address width.
- DATA_W, 64, write data width.
- TAG_W, 13, reqtag width; field layout is defined in the shared package.
- DEPTH, 4, write-buffer entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- core_reqcyc  in  1  core request valid
- core_req  in  ADDR_W  write address
- core_reqdata  in  DATA_W  write data
- core_reqtag  in  TAG_W  {type, space, kind, 7'b0}
- core_reqack  out  1  request accepted (1-cycle pulse)
- core_writeack  out  1  oldest accepted write committed to memory (1-cycle pulse)
- mem_wr_valid  out  1  memory write request valid
- mem_wr_addr  out  ADDR_W  memory write address
- mem_wr_data  out  DATA_W  memory write data
- mem_wr_ready  in  1  memory accepted the request
- mem_wr_done  in  1  memory completed the write
- pending_count  out  $clog2(DEPTH)+1  occupied buffer entries
- busy  out  1  pending_count != 0 or the drain FSM is not IDLE

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0 and the FIFO pointers and count are 0. Drain FSM goes to IDLE.
  - Reset mid-operation discards buffered writes, with no writeack for them. Any mem_wr_valid drops on the next cycle.
- Accept condition, evaluated each cycle: core_reqcyc=1, tag type=WRITE, FIFO not full, and core_reqack=0 in this cycle.
  - On accept, push {req, reqdata} and register core_reqack=1 for exactly the next cycle.
  - Latency from reqcyc to reqack is 1 cycle.
  - The core drops reqcyc on the edge after it sees reqack. The "reqack=0" term blocks the duplicate accept while reqcyc is still high.
- Requests with tag type=READ are never acked and not pushed; core_reqack stays 0.
- When the FIFO is full, the request is held off (no reqack) until an entry pops. The core keeps reqcyc asserted while waiting.
- FIFO:
  - Circular buffer with head/tail pointers that wrap modulo DEPTH.
  - Full when count==DEPTH; empty when count==0.
  - Push and pop in the same cycle leave count unchanged. This is legal even when full, provided the pop frees the slot first; accept is evaluated with full computed pre-pop, so no push occurs when full.
- Drain FSM states:
  - IDLE: if not empty, go to ISSUE.
  - ISSUE: mem_wr_valid=1 with addr/data from the head entry. These hold stable until mem_wr_ready=1, then go to WAIT_DONE.
  - WAIT_DONE: mem_wr_valid=0; on mem_wr_done=1 go to ACK.
  - ACK: core_writeack=1 for this cycle, pop head, return to IDLE.
- mem_wr_ready and mem_wr_done in the same ISSUE cycle: go directly to ACK.
- mem_wr_done outside WAIT_DONE (or same-cycle ISSUE) is ignored.
- Minimum turnaround per write with ready/done in consecutive cycles: IDLE→ISSUE→WAIT_DONE→ACK, so 4 cycles from push to writeack.
- Writes commit strictly in acceptance order. core_writeack pulses exactly once per accepted write.
- Address and data pass through unchanged; no alignment or masking.
- core_reqack and core_writeack may be high in the same cycle. They refer to different requests.

Decomposition:
- Shared package dcache_bus_pkg:
  - Tag field enums: REQ_WRITE/REQ_READ, MEMORY/IO space, DATA/INSTR kind.
  - Tag bit positions, TAG_W.
  - Drain-state enum drain_state_t {DRAIN_IDLE, DRAIN_ISSUE, DRAIN_WAIT, DRAIN_ACK}.
- One sub-module, wr_buffer_fifo (DEPTH × (ADDR_W+DATA_W), push/pop/full/empty/count). The top holds the accept logic and the drain FSM.

Test Plan:
- Reset then a single write: reqcyc=1, req=0x1000, data=0xDEADBEEF, WRITE tag.
  - Required: reqack high in cycle 1 only, then mem_wr_valid with addr 0x1000, data 0xDEADBEEF.
  - With ready next cycle and done the cycle after, writeack pulses once and pending_count returns 0.
- Duplicate guard: hold reqcyc high 2 cycles after reqack. Required: exactly one push (pending_count=1) and one reqack.
- Fill to DEPTH=4 with mem_wr_ready=0.
  - Required: the 5th request gets no reqack while full.
  - Raising ready/done pops one entry; the 5th is then acked and written after the first 4, in order 0x00, 0x08, 0x10, 0x18, 0x20.
- READ tag with reqcyc=1 for 10 cycles. Required: reqack never asserts, pending_count=0, mem_wr_valid=0.
- Back-pressure: mem_wr_ready low for 6 cycles. Required: mem_wr_valid, addr and data stay constant for all 6 cycles; no writeack before done.
- Reset mid-drain, asserted in WAIT_DONE with 2 entries buffered.
  - Required: the next cycle has all outputs 0 and pending_count=0.
  - A later mem_wr_done produces no writeack.
